// File: rtl/demux_sel_sequencer.sv
// demux_sel_sequencer: drives one-hot select and registered data bit for a 1:4 demux, auto round-robin or host-picked
module demux_sel_sequencer #(
  parameter int N_CH    = 4,
  parameter int DWELL_W = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic               i_mode,
  input  logic [DWELL_W-1:0] i_dwell,
  input  logic               i_req,
  input  logic [1:0]         i_ch_idx,
  output logic               o_ack,
  input  logic               i_data,
  output logic               o_a,
  output logic [N_CH-1:0]    o_sel_code,
  output logic [1:0]         o_ch_idx,
  output logic               o_busy,
  output logic               o_wrap
);
  localparam logic [1:0] IDLE = 2'd0, AUTO = 2'd1, MAN = 2'd2;
  logic [1:0] state, state_n, ch, ch_n;
  logic [DWELL_W-1:0] cnt, cnt_n, reload;
  logic ack_n, wrap_n, busy_n;
  // counter holds remaining cycles minus one, so a dwell of 0 behaves like 1
  assign reload = (i_dwell == '0) ? '0 : i_dwell - DWELL_W'(1);
  assign busy_n = state_n != IDLE;
  always_comb begin
    state_n = state;
    ch_n    = ch;
    cnt_n   = cnt;
    ack_n   = 1'b0;
    wrap_n  = 1'b0;
    if (!i_en) begin
      state_n = IDLE;
      ch_n    = '0;
      cnt_n   = '0;
    end else if (state == IDLE) begin
      state_n = i_mode ? MAN : AUTO;
      ch_n    = '0;
      cnt_n   = i_mode ? '0 : reload;
    end else if (state == AUTO && i_mode) begin
      state_n = MAN;
    end else if (state != AUTO && !i_mode) begin
      state_n = AUTO;
      cnt_n   = reload;
    end else if (state == AUTO) begin
      cnt_n  = (cnt != '0) ? cnt - DWELL_W'(1) : reload;
      ch_n   = (cnt != '0) ? ch : ch + 2'd1;
      wrap_n = (cnt == '0) && (ch == 2'd3);
    end else if (i_req) begin
      ch_n  = i_ch_idx;
      ack_n = 1'b1;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      ch         <= '0;
      cnt        <= '0;
      o_ack      <= 1'b0;
      o_wrap     <= 1'b0;
      o_a        <= 1'b0;
      o_sel_code <= '0;
      o_ch_idx   <= '0;
      o_busy     <= 1'b0;
    end else begin
      state      <= state_n;
      ch         <= ch_n;
      cnt        <= cnt_n;
      o_ack      <= ack_n;
      o_wrap     <= wrap_n;
      o_a        <= i_data & busy_n;
      o_sel_code <= busy_n ? N_CH'(1) << ch_n : '0;
      o_ch_idx   <= ch_n;
      o_busy     <= busy_n;
    end
  end
endmodule
